wr_full_ctrl: RTL and testbench
===============================

WR_FULL_CTRL -- requirements
Module: wr_full_ctrl

Interface
REQ-001 SHALL have parameter Addr_width, default 5, meaning log2 of FIFO depth; pointers are Addr_width+1 bits.
REQ-002 SHALL have parameter Almost_full_thr, default 28, meaning the occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk  input  1  write-domain clock; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  producer write request.
REQ-006 SHALL have port wr_addr  input  Addr_width+1  registered binary write pointer from the write counter.
REQ-007 SHALL have port rd_ptr_gray  input  Addr_width+1  Gray read pointer from the read clock domain, asynchronous to clk.
REQ-008 SHALL have port ovf_clr  input  1  clears wr_ovf.
REQ-009 SHALL have port full  output  1  FIFO full; drives the write counter stop input.
REQ-010 SHALL have port almost_full  output  1  occupancy >= Almost_full_thr.
REQ-011 SHALL have port mem_wr_en  output  1  write strobe to the FIFO memory.
REQ-012 SHALL have port wr_ptr_gray  output  Addr_width+1  registered Gray write pointer sent to the read domain.
REQ-013 SHALL have port wr_level  output  Addr_width+1  write-side occupancy, range 0..2^Addr_width.
REQ-014 SHALL have port wr_ovf  output  1  sticky flag: write attempted while full.

Function
REQ-015 SHALL pass rd_ptr_gray through a 2-flop synchronizer clocked by clk, giving rd_gray_s; a change is visible after the 2nd rising edge.
REQ-016 SHALL register wr_ptr_gray = wr_addr ^ (wr_addr >> 1) every cycle, so it lags wr_addr by one clock.
REQ-017 SHALL compute full combinationally from registers only: gray(wr_addr) == {~rd_gray_s[MSB:MSB-1], rd_gray_s[MSB-2:0]}; full therefore affects the counter stop in the same cycle.
REQ-018 SHALL compute wr_level = (wr_addr - gray2bin(rd_gray_s)) mod 2^(Addr_width+1), combinationally.
REQ-019 SHALL assert almost_full when wr_level >= Almost_full_thr; almost_full is 1 whenever full is 1.
REQ-020 SHALL drive mem_wr_en = wr_en & ~full.
REQ-021 SHALL set wr_ovf on the clock edge after any cycle with wr_en & full; ovf_clr clears it; simultaneous set and clear leaves it at 1.
REQ-022 SHALL handle pointer wrap (2^(Addr_width+1)-1 -> 0) with no false full and no level error.
REQ-023 SHALL treat full as pessimistic: a read-side pointer advance releases full only after synchronization; full never deasserts early.

Reset
REQ-024 SHALL clear both synchronizer stages, wr_ptr_gray and wr_ovf to 0 asynchronously when rst=0; full=0, almost_full=0, wr_level=0 then follow from wr_addr=0.
REQ-025 SHALL honour a reset asserted mid-operation (including while full) on the same edge it asserts, independent of clk.

Structure
REQ-026 SHALL take bin2gray and gray2bin functions and the Addr_width default from a shared package (fifo_pkg), which is also used by the read-side empty logic.
REQ-027 SHALL instantiate a sub-module sync_2ff (parameter width, async active-low reset); the read side reuses it.

Verification (Addr_width=5, Almost_full_thr=28)
REQ-028 SHALL test reset: rst=0 -> wr_ptr_gray=0, wr_ovf=0, full=0, almost_full=0, wr_level=0, mem_wr_en=0.
REQ-029 SHALL test fill: rd_ptr_gray=0, step wr_addr 0..32 -> almost_full=1 at 28, full=1 and wr_level=32 at wr_addr=32, mem_wr_en=0 when wr_en=1.
REQ-030 SHALL test overflow: full=1 with wr_en=1 for 1 cycle -> wr_ovf=1 next edge; ovf_clr=1 -> 0; wr_en&full with ovf_clr together -> stays 1.
REQ-031 SHALL test release: full at wr_addr=32, rd_ptr_gray 000000->000001 -> full=0 and wr_level=31 after exactly the 2nd clk edge.
REQ-032 SHALL test wrap: wr_addr=63, rd_ptr_gray=010000 (binary 31) -> full=1, wr_level=32; wr_addr=0, rd_ptr_gray=100000 (binary 63) -> full=0, wr_level=1.
REQ-033 SHALL test mid-operation reset: rst=0 while full -> full=0, wr_ovf=0 and synchronizer cleared before the next clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers used by both the write-side full logic and the
// read-side empty logic.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 5;
    localparam int GRAY_MAX_W         = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Pointers narrower than GRAY_MAX_W arrive zero-extended, so the prefix XOR
    // over the full word gives the right answer for any pointer width.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Only one bit changes per source update, so the captured word is always valid.
module sync_2ff #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] meta_d, meta_q;
    logic [width-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments let both stages sample their inputs from the
    // same edge; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/wr_full_ctrl.sv
// Write-side full/almost-full/level control for an async FIFO: synchronizes the
// read pointer, publishes the Gray write pointer and tracks a sticky overflow flag.
module wr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int Addr_width      = ADDR_WIDTH_DEFAULT,
    parameter int Almost_full_thr = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [Addr_width:0] wr_addr,
    input  logic [Addr_width:0] rd_ptr_gray,
    input  logic                ovf_clr,
    output logic                full,
    output logic                almost_full,
    output logic                mem_wr_en,
    output logic [Addr_width:0] wr_ptr_gray,
    output logic [Addr_width:0] wr_level,
    output logic                wr_ovf
);

    localparam int PtrW = Addr_width + 1;

    logic [PtrW-1:0] rd_gray_s;
    logic [PtrW-1:0] rd_bin_s;
    logic [PtrW-1:0] wr_gray_now;
    logic [PtrW-1:0] wr_ptr_gray_d, wr_ptr_gray_q;
    logic            wr_ovf_d, wr_ovf_q;

    sync_2ff #(
        .width (PtrW)
    ) u_rd_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (rd_ptr_gray),
        .dout  (rd_gray_s)
    );

    // NOTE: every output of this block is assigned unconditionally at the top,
    // so no path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        wr_gray_now = PtrW'(bin2gray(gray_word_t'(wr_addr)));
        rd_bin_s    = PtrW'(gray2bin(gray_word_t'(rd_gray_s)));

        // Full when the write pointer is exactly one lap ahead: in Gray code that
        // is the read pointer with its two top bits inverted.
        full        = (wr_gray_now == {~rd_gray_s[PtrW-1:PtrW-2], rd_gray_s[PtrW-3:0]});
        wr_level    = wr_addr - rd_bin_s;
        almost_full = full | (int'(wr_level) >= Almost_full_thr);
        mem_wr_en   = wr_en & ~full;

        wr_ptr_gray_d = wr_gray_now;
        // Set wins over clear so a write rejected in the clearing cycle is not lost.
        wr_ovf_d      = (wr_ovf_q & ~ovf_clr) | (wr_en & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_gray_q <= '0;
            wr_ovf_q      <= 1'b0;
        end else begin
            wr_ptr_gray_q <= wr_ptr_gray_d;
            wr_ovf_q      <= wr_ovf_d;
        end
    end

    assign wr_ptr_gray = wr_ptr_gray_q;
    assign wr_ovf      = wr_ovf_q;

endmodule

// File: tb/tb_wr_full_ctrl.sv
// Self-checking bench for wr_full_ctrl: directed scenarios plus randomized
// traffic compared against a pointer-arithmetic reference model.
module tb_wr_full_ctrl;

    localparam int AW  = 5;
    localparam int THR = 28;
    localparam int MOD = 64;
    localparam int LAP = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       ovf_clr;
    logic [5:0] wr_addr;
    logic [5:0] rd_ptr_gray;
    logic       full;
    logic       almost_full;
    logic       mem_wr_en;
    logic [5:0] wr_ptr_gray;
    logic [5:0] wr_level;
    logic       wr_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: binary pointers as plain integers.
    int   m_wa;
    int   m_rd_drv;
    int   m_hist[$];
    int   m_ovf;
    int   m_wpg;
    logic m_we;
    logic m_clr;

    wr_full_ctrl #(
        .Addr_width      (AW),
        .Almost_full_thr (THR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .ovf_clr     (ovf_clr),
        .full        (full),
        .almost_full (almost_full),
        .mem_wr_en   (mem_wr_en),
        .wr_ptr_gray (wr_ptr_gray),
        .wr_level    (wr_level),
        .wr_ovf      (wr_ovf)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // Occupancy seen by the write side: read pointer as it was two edges ago.
    function automatic int exp_level();
        return (m_wa - m_hist[0] + MOD) % MOD;
    endfunction

    function automatic logic exp_full();
        return exp_level() == LAP;
    endfunction

    function automatic logic exp_almost();
        return exp_level() >= THR;
    endfunction

    task automatic model_reset();
        m_hist = '{0, 0};
        m_ovf  = 0;
        m_wpg  = 0;
    endtask

    task automatic drive(input int wa, input int rb, input logic we, input logic clr);
        m_wa        = wa;
        m_rd_drv    = rb;
        m_we        = we;
        m_clr       = clr;
        wr_addr     = 6'(wa);
        rd_ptr_gray = 6'(gray_of(rb));
        wr_en       = we;
        ovf_clr     = clr;
    endtask

    task automatic tick();
        if (m_we && exp_full()) m_ovf = 1;
        else if (m_clr)         m_ovf = 0;
        m_wpg = gray_of(m_wa);
        @(posedge clk);
        m_hist.push_back(m_rd_drv);
        void'(m_hist.pop_front());
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 1'b0, 1'b0);
        model_reset();
        #2;
        checks++; if (wr_ptr_gray !== 6'd0) begin errors++; $display("FAIL reset_wr_ptr_gray got %0h exp 0", wr_ptr_gray); end
        checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL reset_wr_ovf got %b exp 0", wr_ovf); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        checks++; if (wr_level !== 6'd0) begin errors++; $display("FAIL reset_wr_level got %0d exp 0", wr_level); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mem_wr_en got %b exp 0", mem_wr_en); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        m_hist.push_back(m_rd_drv);
        void'(m_hist.pop_front());
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i <= LAP; i++) begin
            drive(i, 0, 1'b1, 1'b0);
            #1;
            checks++; if (full !== exp_full()) begin errors++; $display("FAIL fill_full wa=%0d got %b exp %b", i, full, exp_full()); end
            checks++; if (wr_level !== 6'(exp_level())) begin errors++; $display("FAIL fill_level wa=%0d got %0d exp %0d", i, wr_level, exp_level()); end
            checks++; if (almost_full !== (i >= THR)) begin errors++; $display("FAIL fill_almost wa=%0d got %b exp %b", i, almost_full, (i >= THR)); end
            checks++; if (mem_wr_en !== !exp_full()) begin errors++; $display("FAIL fill_mem_wr_en wa=%0d got %b exp %b", i, mem_wr_en, !exp_full()); end
            if (i < LAP) tick();
        end
        checks++; if (full !== 1'b1 || wr_level !== 6'd32) begin errors++; $display("FAIL fill_at_32 got full=%b level=%0d exp full=1 level=32", full, wr_level); end
    endtask

    task automatic test_overflow();
        drive(LAP, 0, 1'b1, 1'b0);
        tick();
        checks++; if (wr_ovf !== 1'b1 || m_ovf != 1) begin errors++; $display("FAIL ovf_set got %b exp 1", wr_ovf); end
        checks++; if (wr_ptr_gray !== 6'(m_wpg)) begin errors++; $display("FAIL ovf_wr_ptr_gray got %0h exp %0h", wr_ptr_gray, m_wpg); end
        drive(LAP, 0, 1'b0, 1'b1);
        tick();
        checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", wr_ovf); end
        drive(LAP, 0, 1'b1, 1'b1);
        tick();
        checks++; if (wr_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_and_clear got %b exp 1", wr_ovf); end
        drive(LAP, 0, 1'b0, 1'b1);
        tick();
        checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_again got %b exp 0", wr_ovf); end
        drive(LAP, 0, 1'b0, 1'b0);
    endtask

    task automatic test_release();
        drive(LAP, 1, 1'b0, 1'b0);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL release_edge0_full got %b exp 1", full); end
        tick();
        checks++; if (full !== 1'b1 || wr_level !== 6'd32) begin errors++; $display("FAIL release_edge1 got full=%b level=%0d exp full=1 level=32", full, wr_level); end
        tick();
        checks++; if (full !== 1'b0 || wr_level !== 6'd31) begin errors++; $display("FAIL release_edge2 got full=%b level=%0d exp full=0 level=31", full, wr_level); end
        checks++; if (full !== exp_full() || wr_level !== 6'(exp_level())) begin errors++; $display("FAIL release_model got full=%b level=%0d exp full=%b level=%0d", full, wr_level, exp_full(), exp_level()); end
    endtask

    task automatic test_wrap();
        drive(63, 31, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (full !== 1'b1 || wr_level !== 6'd32) begin errors++; $display("FAIL wrap_full got full=%b level=%0d exp full=1 level=32", full, wr_level); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL wrap_almost got %b exp 1", almost_full); end
        drive(0, 63, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (full !== 1'b0 || wr_level !== 6'd1) begin errors++; $display("FAIL wrap_zero got full=%b level=%0d exp full=0 level=1", full, wr_level); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL wrap_zero_almost got %b exp 0", almost_full); end
    endtask

    task automatic test_mid_reset();
        drive(37, 5, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL midrst_prefull got %b exp 1", full); end
        drive(37, 5, 1'b1, 1'b0);
        tick();
        checks++; if (wr_ovf !== 1'b1) begin errors++; $display("FAIL midrst_preovf got %b exp 1", wr_ovf); end
        #3;
        rst = 1'b0;
        drive(0, 5, 1'b0, 1'b0);
        model_reset();
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full got %b exp 0", full); end
        checks++; if (wr_level !== 6'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", wr_level); end
        checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", wr_ovf); end
        checks++; if (wr_ptr_gray !== 6'd0) begin errors++; $display("FAIL midrst_wr_ptr_gray got %0h exp 0", wr_ptr_gray); end
        #2;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (wr_level !== 6'(exp_level())) begin errors++; $display("FAIL midrst_resync_level got %0d exp %0d", wr_level, exp_level()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int wa;
            int rb;
            rb = int'($urandom_range(0, MOD - 1));
            wa = int'($urandom_range(0, MOD - 1));
            if ($urandom_range(0, 3) == 0) wa = (m_hist[1] + LAP - int'($urandom_range(0, 4))) % MOD;
            drive(wa, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            checks++; if (mem_wr_en !== (m_we && !exp_full())) begin errors++; $display("FAIL rand_mem_wr_en n=%0d got %b exp %b", n, mem_wr_en, (m_we && !exp_full())); end
            tick();
            checks++; if (full !== exp_full()) begin errors++; $display("FAIL rand_full n=%0d got %b exp %b", n, full, exp_full()); end
            checks++; if (wr_level !== 6'(exp_level())) begin errors++; $display("FAIL rand_level n=%0d got %0d exp %0d", n, wr_level, exp_level()); end
            checks++; if (almost_full !== exp_almost()) begin errors++; $display("FAIL rand_almost n=%0d got %b exp %b", n, almost_full, exp_almost()); end
            checks++; if (wr_ptr_gray !== 6'(m_wpg)) begin errors++; $display("FAIL rand_wr_ptr_gray n=%0d got %0h exp %0h", n, wr_ptr_gray, m_wpg); end
            checks++; if (wr_ovf !== 1'(m_ovf)) begin errors++; $display("FAIL rand_ovf n=%0d got %b exp %0d", n, wr_ovf, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
